dm_access_ctrl: RTL and testbench
=================================

# dm_access_ctrl

Sequencing controller between the CPU memory stage and a variable-latency data memory port. Accepts one load/store per transaction, checks alignment, generates byte-lane enables and replicated write data, drives a req/ack handshake to memory, and stalls the pipeline until completion. Misaligned accesses and, optionally, bus timeouts are reported as exception codes instead of reaching memory.

## Interface
- `TIMEOUT`, default 15: wait cycles in ISSUE before abort (only with `DM_TIMEOUT_EN`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state.
- `cpu_req` in 1: access request from memory stage.
- `cpu_we` in 1: 1 means store, 0 means load.
- `cpu_op` in 3: 000 none, 001 word, 010 byte, 011 half; others are treated as none.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-aligned.
- `cpu_stall` out 1: freeze the pipeline.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: raw memory word, valid while `cpu_done` is 1.
- `cpu_exc` out 2: 00 none, 01 AdEL, 10 AdES, 11 bus timeout; valid while `cpu_done` is 1.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_byteen` out 4: lane enables.
- `mem_wdata` out 32: lane-replicated data.
- `mem_ack` in 1: memory completion.
- `mem_rdata` in 32: read word, valid with `mem_ack`.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- **IDLE:**
  - A request is valid when `cpu_req`=1 and `cpu_op` ∈ {001, 010, 011}.
  - Alignment rules: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned.
  - Aligned request: latch we, op, addr, lanes and data; go to ISSUE.
  - Misaligned request: no memory access; latch `cpu_exc` (01 for a load, 10 for a store); go to DONE.
  - `cpu_op` 000 or invalid: ignored; no stall; stay in IDLE.
- **Lanes:**
  - Word: byteen 1111; data passed through unchanged.
  - Half: byteen 0011 (addr[1]=0) or 1100 (addr[1]=1); data = `{2{wdata[15:0]}}`.
  - Byte: byteen one-hot at addr[1:0] (00 gives 0001 … 11 gives 1000); data = `{4{wdata[7:0]}}`.
  - Loads drive the same byteen; `mem_wdata` is 0. Sign/zero extension is done downstream.
- **ISSUE:**
  - `mem_req`=1 with latched fields held stable until `mem_ack`.
  - On `mem_ack`: capture `mem_rdata`; exc=00; go to DONE. `mem_req` drops on the next edge.
- **DONE:**
  - `cpu_done`=1 and `cpu_stall`=0 for exactly one cycle; then IDLE.
  - New requests are accepted only in IDLE, so back-to-back accesses have a one-cycle gap.
- **Stall:**
  - `cpu_stall` = (IDLE & valid request) | ISSUE.
  - This is combinational from `cpu_req`/`cpu_op` in IDLE only.
  - The misaligned-request cycle also stalls.
- `mem_ack` outside ISSUE is ignored.

## Timing
- Reset values: state IDLE; `cpu_stall`, `cpu_done`, `mem_req`, `mem_we` are 0; `cpu_rdata`, `cpu_exc`, `mem_addr`, `mem_byteen`, `mem_wdata` are 0.
- Latency with an ack in the first ISSUE cycle: accept at cycle 0, `mem_req` at cycle 1, `cpu_done` at cycle 2. Each extra wait cycle adds one.
- Misaligned latency: accept at cycle 0, `cpu_done` with exception at cycle 1.
- Reset asserted mid-transaction drops the transaction immediately: `mem_req` falls asynchronously and no `cpu_done` is produced.
- All outputs except `cpu_stall` are registered.

## Configuration
- Macro: `DM_TIMEOUT_EN`.
- **Defined:**
  - A wait counter clears on entry to ISSUE and increments each ISSUE cycle without ack.
  - Reaching `TIMEOUT` deasserts `mem_req`, sets `cpu_rdata`=0 and `cpu_exc`=11, and goes to DONE.
  - An ack in the same cycle the count reaches `TIMEOUT` wins: normal completion.
- **Undefined:** no counter; ISSUE waits indefinitely; `cpu_exc`=11 never occurs.

## Structure
- Package `dm_pkg` holds:
  - op encodings (NONE/WORD/BYTE/HALF);
  - exception codes (NONE/ADEL/ADES/TMO);
  - the FSM state enum;
  - the default `TIMEOUT`.
- Sub-module `dm_lane_gen` (combinational): op, addr[1:0] and wdata in; byteen, replicated wdata and misaligned flag out.
- The FSM, latches and counter live in `dm_access_ctrl`.

## Test plan
- Store word, addr 0x1000, data 0xDEADBEEF, ack on the first ISSUE cycle -> `mem_byteen` 1111, `mem_wdata` 0xDEADBEEF, `cpu_done` at cycle 2, exc 00.
- Store byte, addr 0x1003, data 0x000000A5, ack after 3 waits -> `mem_addr` 0x1000, byteen 1000, data 0xA5A5A5A5 held stable, `cpu_stall` 1 through ISSUE, `cpu_done` at cycle 5.
- Load half at 0x2001 -> no `mem_req`, `cpu_done` at cycle 1 with exc 01. Store word at 0x2002 -> exc 10.
- Load half at 0x2002, `mem_rdata` 0x12345678 -> byteen 1100, `cpu_rdata` 0x12345678, exc 00.
- `DM_TIMEOUT_EN`, `TIMEOUT`=15, ack never asserted -> `mem_req` drops after 15 ISSUE cycles, exc 11, rdata 0. Repeat with ack exactly at cycle 15 -> normal completion.
- Reset pulled low during ISSUE -> `mem_req` 0 immediately, no `cpu_done`; after release a new access completes normally.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access controller: CPU op codes,
// exception codes, controller states and the default bus-timeout length.
package dm_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_WORD = 3'b001,
        OP_BYTE = 3'b010,
        OP_HALF = 3'b011
    } dm_op_e;

    typedef enum logic [1:0] {
        EXC_NONE = 2'b00,
        EXC_ADEL = 2'b01,
        EXC_ADES = 2'b10,
        EXC_TMO  = 2'b11
    } dm_exc_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } dm_state_e;

    localparam int unsigned DM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/dm_lane_gen.sv
// Byte-lane decode for one access: lane enables, lane-replicated store data
// and the misalignment flag. Purely combinational.
module dm_lane_gen
    import dm_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  byteen,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    // decode lanes and alignment from the access size and low address bits
    always_comb begin
        byteen     = 4'b0000;
        lane_data  = 32'h0;
        misaligned = 1'b0;
        case (op)
            OP_WORD: begin
                byteen     = 4'b1111;
                lane_data  = wdata;
                misaligned = (addr_lo != 2'b00);
            end
            OP_HALF: begin
                byteen     = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            OP_BYTE: begin
                byteen     = 4'b0001 << addr_lo;
                lane_data  = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store sequencer between the CPU memory stage and a variable-latency
// data memory. Optional bus timeout is enabled with `define DM_TIMEOUT_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a valid request; misaligned ones skip memory
// ST_ISSUE | mem_req held with latched fields until mem_ack (or timeout)
// ST_DONE  | one-cycle cpu_done pulse with rdata/exception
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned TIMEOUT = DM_TIMEOUT_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_op,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic [1:0]  cpu_exc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    dm_state_e   state, state_nxt;
    logic        acc_valid;
    logic        tmo_hit;
    logic [3:0]  byteen;
    logic [31:0] lane_data;
    logic        misaligned;

    dm_lane_gen u_lane_gen (
        .op         (cpu_op),
        .addr_lo    (cpu_addr[1:0]),
        .wdata      (cpu_wdata),
        .byteen     (byteen),
        .lane_data  (lane_data),
        .misaligned (misaligned)
    );

    assign acc_valid = cpu_req && (cpu_op inside {OP_WORD, OP_BYTE, OP_HALF});

    // stall is the only combinational output: it must freeze the pipeline
    // in the same cycle the request is presented
    assign cpu_stall = ((state == ST_IDLE) && acc_valid) || (state == ST_ISSUE);

`ifdef DM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // count ISSUE cycles without ack; held at zero outside ISSUE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (state != ST_ISSUE)
            wait_cnt <= '0;
        else if (!mem_ack)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // this cycle's miss brings the count to TIMEOUT; an ack in it still wins
    assign tmo_hit = (state == ST_ISSUE) && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (acc_valid) state_nxt = misaligned ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (mem_ack || tmo_hit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // registered outputs: latch the access on accept, capture the result on completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_done   <= 1'b0;
            cpu_rdata  <= 32'h0;
            cpu_exc    <= EXC_NONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_byteen <= 4'b0000;
            mem_wdata  <= 32'h0;
        end else begin
            cpu_done <= (state_nxt == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (acc_valid) begin
                        if (misaligned) begin
                            cpu_exc   <= cpu_we ? EXC_ADES : EXC_ADEL;
                            cpu_rdata <= 32'h0;
                        end else begin
                            mem_req    <= 1'b1;
                            mem_we     <= cpu_we;
                            mem_addr   <= {cpu_addr[31:2], 2'b00};
                            mem_byteen <= byteen;
                            mem_wdata  <= cpu_we ? lane_data : 32'h0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_rdata <= mem_rdata;
                        cpu_exc   <= EXC_NONE;
                    end else if (tmo_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_rdata <= 32'h0;
                        cpu_exc   <= EXC_TMO;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl. Expected per-cycle behaviour is
// derived from each access's size, address and ack timing.
module tb_dm_access_ctrl;

    localparam int TMO = 15;
`ifdef DM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [2:0]  cpu_op;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_done;
    logic [31:0] cpu_rdata;
    logic [1:0]  cpu_exc;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    dm_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_op     (cpu_op),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .cpu_exc    (cpu_exc),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // expected values for the current cycle
    bit          chk_en = 1'b0;
    bit          exp_stall, exp_req, exp_done, exp_we, chk_rd;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;
    logic [1:0]  exp_exc;

    // observations from the last access
    int          obs_done, obs_req_cycles;
    logic [31:0] obs_addr, obs_wd, obs_rd;
    logic [3:0]  obs_be;
    logic [1:0]  obs_exc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // lane model: an access of 'size' bytes at byte offset a covers lanes
    // a..a+size-1; each lane carries wdata byte (lane mod size)
    function automatic void model_lanes(input int size, input int a, input logic [31:0] wd,
                                        output logic [3:0] be, output logic [31:0] rep);
        be  = '0;
        rep = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= a && i < a + size) be[i] = 1'b1;
            rep[8*i +: 8] = wd[8*(i % size) +: 8];
        end
    endfunction

    function automatic int op_size(input logic [2:0] op);
        return (op == 3'b001) ? 4 : (op == 3'b011) ? 2 : 1;
    endfunction

    // the single compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(cpu_stall), 32'(exp_stall));
            chk("done", 32'(cpu_done), 32'(exp_done));
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) begin
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_byteen", 32'(mem_byteen), 32'(exp_be));
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_done) begin
                chk("cpu_exc", 32'(cpu_exc), 32'(exp_exc));
                if (chk_rd) chk("cpu_rdata", cpu_rdata, exp_rdata);
            end
        end
    end

    // ack_cyc: ISSUE cycle (1-based) in which mem_ack is given; 0 = never
    task automatic access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int ack_cyc, input logic [31:0] rd);
        int sz, a, issue_len, done_c;
        bit mis, tmo;
        logic [3:0]  be;
        logic [31:0] rep;
        sz  = op_size(op);
        a   = int'(addr[1:0]);
        mis = (a % sz) != 0;
        model_lanes(sz, a, wd, be, rep);
        tmo = 1'b0;
        if (mis) issue_len = 0;
        else if (TMO_EN && (ack_cyc == 0 || ack_cyc > TMO)) begin
            issue_len = TMO;
            tmo = 1'b1;
        end else issue_len = ack_cyc;
        done_c = issue_len + 1;
        obs_done = -1; obs_req_cycles = 0;
        obs_addr = '0; obs_wd = '0; obs_rd = '0; obs_be = '0; obs_exc = '0;
        chk_en = 1'b1;
        for (int c = 0; c <= done_c + 1; c++) begin
            @(posedge clk); #1;
            cpu_req   = (c < done_c);
            cpu_we    = we;
            cpu_op    = op;
            cpu_addr  = addr;
            cpu_wdata = wd;
            mem_ack   = !mis && !tmo && c >= 1 && c == ack_cyc;
            mem_rdata = mem_ack ? rd : 32'hBAD0_BAD0;
            exp_stall = (c == 0) || (c >= 1 && c <= issue_len);
            exp_req   = (c >= 1 && c <= issue_len);
            exp_done  = (c == done_c);
            exp_we    = we;
            exp_addr  = {addr[31:2], 2'b00};
            exp_be    = be;
            exp_wdata = we ? rep : 32'h0;
            exp_exc   = mis ? (we ? 2'b10 : 2'b01) : (tmo ? 2'b11 : 2'b00);
            chk_rd    = !mis;
            exp_rdata = tmo ? 32'h0 : rd;
            @(negedge clk);
            if (cpu_done && obs_done < 0) begin
                obs_done = c;
                obs_exc  = cpu_exc;
                obs_rd   = cpu_rdata;
            end
            if (mem_req) begin
                obs_req_cycles++;
                obs_addr = mem_addr;
                obs_be   = mem_byteen;
                obs_wd   = mem_wdata;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic idle(input int n, input logic req, input logic [2:0] op, input logic ack);
        chk_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cpu_req   = req;
            cpu_op    = op;
            cpu_we    = 1'b1;
            cpu_addr  = 32'h0000_1001;
            cpu_wdata = 32'h1111_2222;
            mem_ack   = ack;
            mem_rdata = 32'h5555_AAAA;
            exp_stall = 1'b0;
            exp_req   = 1'b0;
            exp_done  = 1'b0;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        cpu_req = 1'b0;
    endtask

    initial begin
        int dones;
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_op = 3'b000;
        cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_done", 32'(cpu_done), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_exc", 32'(cpu_exc), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_byteen", 32'(mem_byteen), 32'd0);
        chk("rst_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // ack outside ISSUE and none/invalid ops are ignored
        idle(2, 1'b0, 3'b001, 1'b1);
        idle(1, 1'b1, 3'b000, 1'b0);
        idle(1, 1'b1, 3'b100, 1'b1);
        idle(1, 1'b1, 3'b111, 1'b0);

        access(1'b1, 3'b001, 32'h0000_1000, 32'hDEAD_BEEF, 1, 32'h0);
        chk("sw_done_cyc", 32'(obs_done), 32'd2);
        chk("sw_byteen", 32'(obs_be), 32'h0000_000F);
        chk("sw_wdata", obs_wd, 32'hDEAD_BEEF);
        chk("sw_exc", 32'(obs_exc), 32'd0);

        access(1'b1, 3'b010, 32'h0000_1003, 32'h0000_00A5, 4, 32'h0);
        chk("sb_addr", obs_addr, 32'h0000_1000);
        chk("sb_byteen", 32'(obs_be), 32'h0000_0008);
        chk("sb_wdata", obs_wd, 32'hA5A5_A5A5);
        chk("sb_done_cyc", 32'(obs_done), 32'd5);
        chk("sb_req_cycles", 32'(obs_req_cycles), 32'd4);

        access(1'b0, 3'b011, 32'h0000_2001, 32'h0, 1, 32'h0);
        chk("lh_mis_done_cyc", 32'(obs_done), 32'd1);
        chk("lh_mis_exc", 32'(obs_exc), 32'd1);
        chk("lh_mis_no_req", 32'(obs_req_cycles), 32'd0);

        access(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 1, 32'h0);
        chk("sw_mis_exc", 32'(obs_exc), 32'd2);

        access(1'b0, 3'b011, 32'h0000_2002, 32'h0, 1, 32'h1234_5678);
        chk("lh_byteen", 32'(obs_be), 32'h0000_000C);
        chk("lh_rdata", obs_rd, 32'h1234_5678);
        chk("lh_exc", 32'(obs_exc), 32'd0);

        access(1'b0, 3'b001, 32'h0000_4000, 32'h0, 2, 32'hCAFE_F00D);
        access(1'b0, 3'b010, 32'h0000_4002, 32'h0, 1, 32'h0102_0304);
        chk("lb_byteen", 32'(obs_be), 32'h0000_0004);
        access(1'b1, 3'b011, 32'h0000_4000, 32'h1234_BEEF, 3, 32'h0);
        chk("sh_wdata", obs_wd, 32'hBEEF_BEEF);
        chk("sh_byteen", 32'(obs_be), 32'h0000_0003);
        access(1'b1, 3'b010, 32'h0000_4001, 32'h0000_003C, 1, 32'h0);
        chk("sb1_byteen", 32'(obs_be), 32'h0000_0002);
        access(1'b0, 3'b011, 32'h0000_4003, 32'h0, 1, 32'h0);
        access(1'b1, 3'b011, 32'h0000_4003, 32'h0, 1, 32'h0);
        access(1'b0, 3'b001, 32'h0000_4001, 32'h0, 1, 32'h0);
        access(1'b0, 3'b001, 32'h0000_4003, 32'h0, 1, 32'h0);
        access(1'b1, 3'b011, 32'h0000_4002, 32'hFFFF_0707, 1, 32'h0);

        // ack exactly at the timeout boundary completes normally
        access(1'b0, 3'b001, 32'h0000_5000, 32'h0, 15, 32'h0BAD_F00D);
        chk("ack15_done_cyc", 32'(obs_done), 32'd16);
        chk("ack15_exc", 32'(obs_exc), 32'd0);
        chk("ack15_rdata", obs_rd, 32'h0BAD_F00D);

        // late ack: aborted with timeout when enabled, otherwise waits it out
        access(1'b0, 3'b001, 32'h0000_5004, 32'h0, 21, 32'h7777_8888);
`ifdef DM_TIMEOUT_EN
        chk("late_done_cyc", 32'(obs_done), 32'd16);
        chk("late_exc", 32'(obs_exc), 32'd3);
        chk("late_rdata", obs_rd, 32'h0);
        access(1'b1, 3'b001, 32'h0000_5008, 32'h1357_9BDF, 0, 32'h0);
        chk("noack_req_cycles", 32'(obs_req_cycles), 32'd15);
        chk("noack_exc", 32'(obs_exc), 32'd3);
`else
        chk("late_done_cyc", 32'(obs_done), 32'd22);
        chk("late_exc", 32'(obs_exc), 32'd0);
        chk("late_rdata", obs_rd, 32'h7777_8888);
`endif

        // reset during ISSUE drops the transaction at once
        chk_en = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_op = 3'b001;
        cpu_addr = 32'h0000_3000; cpu_wdata = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1 chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        cpu_req = 1'b0;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_done) dones++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_done || mem_req) dones++;
        end
        chk("rst_mid_no_done", 32'(dones), 32'd0);

        access(1'b1, 3'b001, 32'h0000_3000, 32'h0F0F_0F0F, 1, 32'h0);
        chk("post_rst_done_cyc", 32'(obs_done), 32'd2);
        chk("post_rst_exc", 32'(obs_exc), 32'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
